control_unit: RTL and testbench

- Instruction sequencer for the 16-bit programmable processor.
- Holds the PC and IR, fetches from instruction ROM, decodes, and runs a Moore FSM.
- Directly drives the ALU function select, register-file ports and data-memory controls, so it sits immediately upstream of the ALU and datapath.
- Programs end with HALT; restart only via reset.

---
 rtl/cu_pkg.sv | 79 +++++++
 rtl/control_unit_if.sv | 34 +++
 rtl/pc_ir_regs.sv | 36 +++
 rtl/control_unit.sv | 197 +++++++++++++++++++
 tb/tb_control_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the control_unit sequencer.
//   state_e     - FSM state encoding (also exported on State_Out for debug)
//   opcode_e    - instruction opcode in IR[15:12]
//   ALU_*       - ALU function select codes driven on ALU_Sel
//   F_*         - instruction field slice positions
//   alu_sel_of  - opcode to ALU function select
package cu_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_STORE  = 4'd7,
    S_ALU_EX = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_XOR   = 4'h6,
    OP_OR    = 4'h7,
    OP_AND   = 4'h8,
    OP_INC   = 4'h9,
    OP_MOV   = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } opcode_e;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MOV  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  // Instruction field positions
  localparam int F_OP_HI    = 15;
  localparam int F_OP_LO    = 12;
  localparam int F_LDA_HI   = 11;  // LOAD data address
  localparam int F_LDA_LO   = 4;
  localparam int F_STA_HI   = 7;   // STORE data address
  localparam int F_STA_LO   = 0;
  localparam int F_RA_HI    = 11;
  localparam int F_RA_LO    = 8;
  localparam int F_RB_HI    = 7;
  localparam int F_RB_LO    = 4;
  localparam int F_RD_HI    = 3;
  localparam int F_RD_LO    = 0;

  function automatic logic [2:0] alu_sel_of(input opcode_e op);
    logic [2:0] sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_XOR:  sel = ALU_XOR;
      OP_OR:   sel = ALU_OR;
      OP_AND:  sel = ALU_AND;
      OP_INC:  sel = ALU_INC;
      OP_MOV:  sel = ALU_MOV;
      default: sel = ALU_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction-ROM, data-memory, register-file and ALU
// control bundle between the sequencer and the datapath.
//   master - control_unit side: drives addresses/enables, receives IM_Data
//   slave  - datapath/memory side
interface control_unit_if #(
  parameter int PC_W = 7,
  parameter int DA_W = 8,
  parameter int RA_W = 4
);

  logic [15:0]     IM_Data;
  logic [PC_W-1:0] IM_Addr;
  logic [DA_W-1:0] D_Addr;
  logic            D_Wr;
  logic            RF_s;
  logic [RA_W-1:0] RF_W_Addr;
  logic            RF_W_En;
  logic [RA_W-1:0] RF_Ra_Addr;
  logic [RA_W-1:0] RF_Rb_Addr;
  logic [2:0]      ALU_Sel;

  modport master (
    input  IM_Data,
    output IM_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel
  );

  modport slave (
    output IM_Data,
    input  IM_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel
  );

endinterface

// File: rtl/pc_ir_regs.sv
// pc_ir_regs: program counter and instruction register.
//   Clk, ResetN - clock, synchronous active-low reset (PC=0, IR=0)
//   pc_clr      - clear PC (has priority over pc_inc)
//   pc_inc      - PC <= PC + 1, wrapping modulo 2^PC_W
//   ir_ld       - IR <= ir_d
//   pc, ir      - current register values
module pc_ir_regs #(
  parameter int PC_W = 7
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            pc_clr,
  input  logic            pc_inc,
  input  logic            ir_ld,
  input  logic [15:0]     ir_d,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir
);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_clr) begin
        pc <= '0;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
      if (ir_ld) begin
        ir <= ir_d;
      end
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the 16-bit processor.
// Fetches from a synchronous instruction ROM, decodes IR[15:12] and drives
// the ALU select, register-file ports and data-memory controls as Moore
// outputs. A program ends with HALT; only reset leaves HALT.
//
// Ports:
//   Clk        - system clock, rising edge
//   ResetN     - synchronous active-low reset
//   bus        - control_unit_if.master (IM_Data in; IM_Addr, D_Addr, D_Wr,
//                RF_s, RF_W_Addr, RF_W_En, RF_Ra_Addr, RF_Rb_Addr, ALU_Sel out)
//   Halted     - high while in HALT
//   State_Out  - current state encoding (debug)
//   PC_Out     - PC (debug)
//   IR_Out     - IR (debug)
//   Illegal    - only with CU_ILLEGAL_TRAP_EN: sticky flag, set when an
//                opcode B-F traps to HALT
//
// Build option CU_ILLEGAL_TRAP_EN: opcodes B-F halt and set Illegal.
// Without it, B-F execute as NOOP.
//
// state    | meaning
// ---------+-----------------------------------------------
// INIT     | after reset; clears PC
// FETCH    | PC on IM_Addr, ROM read in flight
// LATCH    | IR <= IM_Data, PC <= PC + 1
// DECODE   | dispatch on opcode
// NOOP     | idle cycle for NOOP (and B-F without trap)
// LOAD_A   | D_Addr presented to data memory, RF_s = 1
// LOAD_B   | memory data written into Rd
// STORE    | D_Wr with Ra as data source
// ALU_EX   | ALU result written into Rd
// HALT     | frozen until reset
module control_unit
  import cu_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clk,
  input  logic            ResetN,
  control_unit_if.master  bus,
  output logic            Halted,
  output logic [3:0]      State_Out,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic            Illegal
`endif
);

  state_e          state;
  state_e          state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  opcode_e         op;
  logic            pc_clr;
  logic            pc_inc;
  logic            ir_ld;

  logic [DA_W-1:0] d_addr_q;
  logic            d_wr_q;
  logic            rf_s_q;
  logic [RA_W-1:0] rf_w_addr_q;
  logic            rf_w_en_q;
  logic [RA_W-1:0] rf_ra_q;
  logic [RA_W-1:0] rf_rb_q;
  logic [2:0]      alu_sel_q;
  logic            halted_q;

  assign op     = opcode_e'(ir[F_OP_HI:F_OP_LO]);
  assign pc_clr = (state == S_INIT);
  assign pc_inc = (state == S_LATCH);
  assign ir_ld  = (state == S_LATCH);

  pc_ir_regs #(.PC_W(PC_W)) u_pc_ir (
    .Clk    (Clk),
    .ResetN (ResetN),
    .pc_clr (pc_clr),
    .pc_inc (pc_inc),
    .ir_ld  (ir_ld),
    .ir_d   (bus.IM_Data),
    .pc     (pc),
    .ir     (ir)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_NOOP:  state_nxt = S_NOOP;
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_HALT:  state_nxt = S_HALT;
          OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC, OP_MOV:
                    state_nxt = S_ALU_EX;
`ifdef CU_ILLEGAL_TRAP_EN
          default:  state_nxt = S_HALT;
`else
          default:  state_nxt = S_NOOP;
`endif
        endcase
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ALU_EX, S_NOOP:
                state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered
  // yet still line up with the state they belong to. IR is stable from
  // DECODE until the next LATCH, so reading it here is safe.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state       <= S_INIT;
      d_addr_q    <= '0;
      d_wr_q      <= 1'b0;
      rf_s_q      <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_en_q   <= 1'b0;
      rf_ra_q     <= '0;
      rf_rb_q     <= '0;
      alu_sel_q   <= ALU_ZERO;
      halted_q    <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      Illegal     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      d_addr_q    <= '0;
      d_wr_q      <= 1'b0;
      rf_s_q      <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_en_q   <= 1'b0;
      rf_ra_q     <= '0;
      rf_rb_q     <= '0;
      alu_sel_q   <= ALU_ZERO;
      halted_q    <= 1'b0;
      case (state_nxt)
        S_LOAD_A: begin
          d_addr_q <= DA_W'(ir[F_LDA_HI:F_LDA_LO]);
          rf_s_q   <= 1'b1;
        end
        S_LOAD_B: begin
          d_addr_q    <= DA_W'(ir[F_LDA_HI:F_LDA_LO]);
          rf_s_q      <= 1'b1;
          rf_w_en_q   <= 1'b1;
          rf_w_addr_q <= RA_W'(ir[F_RD_HI:F_RD_LO]);
        end
        S_STORE: begin
          d_wr_q   <= 1'b1;
          d_addr_q <= DA_W'(ir[F_STA_HI:F_STA_LO]);
          rf_ra_q  <= RA_W'(ir[F_RA_HI:F_RA_LO]);
        end
        S_ALU_EX: begin
          rf_ra_q     <= RA_W'(ir[F_RA_HI:F_RA_LO]);
          rf_rb_q     <= RA_W'(ir[F_RB_HI:F_RB_LO]);
          alu_sel_q   <= alu_sel_of(op);
          rf_w_en_q   <= 1'b1;
          rf_w_addr_q <= RA_W'(ir[F_RD_HI:F_RD_LO]);
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: ;
      endcase
`ifdef CU_ILLEGAL_TRAP_EN
      if (state == S_DECODE && op >= OP_RSV_B) begin
        Illegal <= 1'b1;
      end
`endif
    end
  end

  assign bus.IM_Addr    = pc;
  assign bus.D_Addr     = d_addr_q;
  assign bus.D_Wr       = d_wr_q;
  assign bus.RF_s       = rf_s_q;
  assign bus.RF_W_Addr  = rf_w_addr_q;
  assign bus.RF_W_En    = rf_w_en_q;
  assign bus.RF_Ra_Addr = rf_ra_q;
  assign bus.RF_Rb_Addr = rf_rb_q;
  assign bus.ALU_Sel    = alu_sel_q;

  assign Halted    = halted_q;
  assign State_Out = state;
  assign PC_Out    = pc;
  assign IR_Out    = ir;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        halted;
  logic [3:0]  state_out;
  logic [6:0]  pc_out;
  logic [15:0] ir_out;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        illegal;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  control_unit_if #(.PC_W(7), .DA_W(8), .RA_W(4)) bus ();

  control_unit #(.PC_W(7), .DA_W(8), .RA_W(4)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .bus       (bus),
    .Halted    (halted),
    .State_Out (state_out),
    .PC_Out    (pc_out),
    .IR_Out    (ir_out)
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    .Illegal   (illegal)
`endif
  );

  // Synchronous instruction ROM: data valid one cycle after the address.
  logic [15:0] rom [128];
  always @(posedge Clk) bus.IM_Data <= rom[bus.IM_Addr];

  // Reference model: expected per-cycle outputs derived from the program.
  typedef struct packed {
    logic       wen;
    logic       dwr;
    logic       hlt;
    logic [6:0] pc;
    logic [2:0] alu;
    logic       s;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] da;
  } vec_t;
  typedef struct packed { logic s, wa, ra, rb, da; } care_t;
  typedef struct packed { vec_t v; care_t c; } exp_t;
  exp_t exp_q[$];

  function automatic exp_t idle(input logic [6:0] p);
    exp_t e;
    e = '0;
    e.v.pc = p;
    return e;
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h3:    return 3'd1;
      4'h4:    return 3'd2;
      4'h6:    return 3'd4;
      4'h7:    return 3'd5;
      4'h8:    return 3'd6;
      4'h9:    return 3'd7;
      4'hA:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // Each instruction: FETCH, LATCH (PC still old), DECODE (PC advanced),
  // then its execute cycles; HALT holds forever.
  task automatic build_model();
    logic [6:0]  pc;
    logic        done;
    logic [15:0] w;
    logic [3:0]  op;
    exp_t        e;
    pc = 7'd0;
    done = 1'b0;
    exp_q.delete();
    while (!done && exp_q.size() < 2000) begin
      w  = rom[pc];
      op = w[15:12];
      exp_q.push_back(idle(pc));
      exp_q.push_back(idle(pc));
      pc = pc + 7'd1;
      exp_q.push_back(idle(pc));
      if (op == 4'h5 || (TRAP && op >= 4'hB)) begin
        done = 1'b1;
      end else if (op == 4'h1) begin
        e = idle(pc);
        e.v.dwr = 1'b1; e.v.da = w[7:0]; e.v.ra = w[11:8];
        e.c.da = 1'b1;  e.c.ra = 1'b1;
        exp_q.push_back(e);
      end else if (op == 4'h2) begin
        e = idle(pc);
        e.v.da = w[11:4]; e.v.s = 1'b1;
        e.c.da = 1'b1;    e.c.s = 1'b1;
        exp_q.push_back(e);
        e.v.wen = 1'b1; e.v.wa = w[3:0]; e.c.wa = 1'b1;
        exp_q.push_back(e);
      end else if (alu_code(op) != 3'd0) begin
        e = idle(pc);
        e.v.wen = 1'b1; e.v.alu = alu_code(op); e.v.s = 1'b0;
        e.v.wa = w[3:0]; e.v.ra = w[11:8]; e.v.rb = w[7:4];
        e.c.s = 1'b1; e.c.wa = 1'b1; e.c.ra = 1'b1; e.c.rb = 1'b1;
        exp_q.push_back(e);
      end else begin
        exp_q.push_back(idle(pc));
      end
    end
    for (int i = 0; i < 10; i++) begin
      e = idle(pc);
      e.v.hlt = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  // Returns at the first sample after release: the FETCH of PC 0.
  task automatic do_reset();
    ResetN = 1'b0;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    clear_rom();
    ResetN = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (state_out !== 4'd0 || pc_out !== 7'd0 || ir_out !== 16'h0 || bus.IM_Addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d pc=%0d ir=%h im_addr=%0d, want 0/0/0/0",
               state_out, pc_out, ir_out, bus.IM_Addr);
    end
    checks++;
    if ({bus.RF_W_En, bus.D_Wr, halted, bus.ALU_Sel, bus.D_Addr, bus.RF_W_Addr,
         bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b dwr=%b halted=%b alu=%0d daddr=%h, want all 0",
               bus.RF_W_En, bus.D_Wr, halted, bus.ALU_Sel, bus.D_Addr);
    end
    ResetN = 1'b1;
    @(negedge Clk);
    checks++;
    if (state_out !== 4'd1 || bus.IM_Addr !== 7'd0 || bus.RF_W_En !== 1'b0 || bus.D_Wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d im_addr=%0d wen=%b dwr=%b, want 1/0/0/0",
               state_out, bus.IM_Addr, bus.RF_W_En, bus.D_Wr);
    end
  endtask

  task automatic test_load();
    clear_rom();
    rom[0] = 16'h21B3;
    do_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if (state_out !== 4'd5 || bus.D_Addr !== 8'h1B || bus.RF_s !== 1'b1 ||
        bus.RF_W_En !== 1'b0 || pc_out !== 7'd1) begin
      errors++;
      $display("FAIL load_a: state=%0d daddr=%h rf_s=%b wen=%b pc=%0d, want 5/1b/1/0/1",
               state_out, bus.D_Addr, bus.RF_s, bus.RF_W_En, pc_out);
    end
    @(negedge Clk);
    checks++;
    if (bus.RF_W_En !== 1'b1 || bus.RF_s !== 1'b1 || bus.RF_W_Addr !== 4'd3 || bus.D_Addr !== 8'h1B) begin
      errors++;
      $display("FAIL load_b: wen=%b rf_s=%b waddr=%0d daddr=%h, want 1/1/3/1b",
               bus.RF_W_En, bus.RF_s, bus.RF_W_Addr, bus.D_Addr);
    end
    @(negedge Clk);
    checks++;
    if (state_out !== 4'd1 || bus.IM_Addr !== 7'd1 || bus.RF_W_En !== 1'b0) begin
      errors++;
      $display("FAIL load_cycles: state=%0d im_addr=%0d wen=%b after 5 cycles, want 1/1/0",
               state_out, bus.IM_Addr, bus.RF_W_En);
    end
  endtask

  task automatic test_add();
    int wen_cnt;
    clear_rom();
    rom[0] = 16'h3125;
    wen_cnt = 0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (bus.RF_W_En === 1'b1) wen_cnt++;
      if (k == 3) begin
        checks++;
        if (state_out !== 4'd8 || bus.ALU_Sel !== 3'd1 || bus.RF_Ra_Addr !== 4'd1 ||
            bus.RF_Rb_Addr !== 4'd2 || bus.RF_W_Addr !== 4'd5 || bus.RF_s !== 1'b0) begin
          errors++;
          $display("FAIL add_exec: state=%0d alu=%0d ra=%0d rb=%0d waddr=%0d rf_s=%b, want 8/1/1/2/5/0",
                   state_out, bus.ALU_Sel, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.RF_W_Addr, bus.RF_s);
        end
      end
      if (k == 4) begin
        checks++;
        if (state_out !== 4'd1 || bus.ALU_Sel !== 3'd0) begin
          errors++;
          $display("FAIL add_cycles: state=%0d alu=%0d after 4 cycles, want 1/0", state_out, bus.ALU_Sel);
        end
      end
    end
    checks++;
    if (wen_cnt !== 1) begin
      errors++;
      $display("FAIL add_wen_pulse: wen cycles=%0d, want 1", wen_cnt);
    end
  endtask

  task automatic test_store_halt();
    int         dwr_cnt;
    int         bad;
    logic [7:0] st_addr;
    logic [3:0] st_ra;
    clear_rom();
    rom[0] = 16'h1A40;
    rom[1] = 16'h5000;
    dwr_cnt = 0;
    bad = 0;
    st_addr = 8'h00;
    st_ra = 4'h0;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (bus.D_Wr === 1'b1) begin
        dwr_cnt++;
        st_addr = bus.D_Addr;
        st_ra = bus.RF_Ra_Addr;
      end
      if (k == 7) begin
        checks++;
        if (halted !== 1'b1 || state_out !== 4'd9) begin
          errors++;
          $display("FAIL halt_enter: halted=%b state=%0d, want 1/9", halted, state_out);
        end
      end
      if (k >= 8 && k < 28) begin
        if (halted !== 1'b1 || pc_out !== 7'd2 || bus.RF_W_En !== 1'b0 || bus.D_Wr !== 1'b0) bad++;
      end
    end
    checks++;
    if (dwr_cnt !== 1 || st_addr !== 8'h40 || st_ra !== 4'hA) begin
      errors++;
      $display("FAIL store: dwr cycles=%0d daddr=%h ra=%h, want 1/40/a", dwr_cnt, st_addr, st_ra);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL halt_hold: %0d bad cycles (pc=%0d halted=%b), want 0", bad, pc_out, halted);
    end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    do_reset();
    for (int k = 1; k <= 512; k++) begin
      @(negedge Clk);
      if (k == 508) begin
        checks++;
        if (pc_out !== 7'd127 || state_out !== 4'd1) begin
          errors++;
          $display("FAIL wrap_last: pc=%0d state=%0d, want 127/1", pc_out, state_out);
        end
      end
      if (k == 512) begin
        checks++;
        if (pc_out !== 7'd0 || state_out !== 4'd1) begin
          errors++;
          $display("FAIL wrap_zero: pc=%0d state=%0d after 512 cycles, want 0/1", pc_out, state_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_rom();
    rom[0] = 16'h21B3;
    do_reset();
    repeat (4) @(negedge Clk);
    checks++;
    if (state_out !== 4'd6 || bus.RF_W_En !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: state=%0d wen=%b, want 6/1", state_out, bus.RF_W_En);
    end
    ResetN = 1'b0;
    @(negedge Clk);
    checks++;
    if (state_out !== 4'd0 || bus.RF_W_En !== 1'b0 || bus.D_Addr !== 8'h00 ||
        pc_out !== 7'd0 || ir_out !== 16'h0) begin
      errors++;
      $display("FAIL midrst: state=%0d wen=%b daddr=%h pc=%0d ir=%h, want 0/0/0/0/0",
               state_out, bus.RF_W_En, bus.D_Addr, pc_out, ir_out);
    end
    ResetN = 1'b1;
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[0] = 16'hF000;
    rom[1] = 16'h3125;
    do_reset();
    repeat (3) @(negedge Clk);
`ifdef CU_ILLEGAL_TRAP_EN
    checks++;
    if (state_out !== 4'd9 || halted !== 1'b1 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_trap: state=%0d halted=%b illegal=%b, want 9/1/1", state_out, halted, illegal);
    end
    repeat (10) @(negedge Clk);
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || pc_out !== 7'd1 || bus.RF_W_En !== 1'b0) begin
      errors++;
      $display("FAIL illegal_hold: illegal=%b halted=%b pc=%0d wen=%b, want 1/1/1/0",
               illegal, halted, pc_out, bus.RF_W_En);
    end
`else
    checks++;
    if (state_out !== 4'd4 || halted !== 1'b0 || bus.RF_W_En !== 1'b0) begin
      errors++;
      $display("FAIL illegal_noop: state=%0d halted=%b wen=%b, want 4/0/0", state_out, halted, bus.RF_W_En);
    end
    @(negedge Clk);
    checks++;
    if (state_out !== 4'd1 || pc_out !== 7'd1) begin
      errors++;
      $display("FAIL illegal_next: state=%0d pc=%0d, want 1/1", state_out, pc_out);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (bus.RF_W_En !== 1'b1 || bus.RF_W_Addr !== 4'd5 || bus.ALU_Sel !== 3'd1) begin
      errors++;
      $display("FAIL illegal_resume: wen=%b waddr=%0d alu=%0d, want 1/5/1",
               bus.RF_W_En, bus.RF_W_Addr, bus.ALU_Sel);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  op;
    int          len;
    exp_t        e;
    vec_t        o;
    for (int trial = 0; trial < 15; trial++) begin
      clear_rom();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'h5) op = op + 4'h1;
        r = $urandom();
        rom[i] = {op, r[11:0]};
      end
      rom[len] = 16'h5000;
      build_model();
      do_reset();
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k > 0) @(negedge Clk);
        e = exp_q[k];
        o.wen = bus.RF_W_En;
        o.dwr = bus.D_Wr;
        o.hlt = halted;
        o.pc  = pc_out;
        o.alu = bus.ALU_Sel;
        o.s   = e.c.s  ? bus.RF_s       : 1'b0;
        o.wa  = e.c.wa ? bus.RF_W_Addr  : 4'h0;
        o.ra  = e.c.ra ? bus.RF_Ra_Addr : 4'h0;
        o.rb  = e.c.rb ? bus.RF_Rb_Addr : 4'h0;
        o.da  = e.c.da ? bus.D_Addr     : 8'h00;
        checks++;
        if (o !== e.v) begin
          errors++;
          $display("FAIL random trial %0d cycle %0d ir=%h: got %h want %h", trial, k, ir_out, o, e.v);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_store_halt();
    test_pc_wrap();
    test_reset_mid_load();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
